// File: rtl/bus_uart_pkg.sv
// Shared definitions for bus_uart: register offsets, STATUS/CTRL bit positions and FSM states.
package bus_uart_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  localparam int ST_RX_AVAIL  = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_TX_BUSY   = 4;

  localparam int CT_RX_IRQ_EN = 0;
  localparam int CT_TX_IRQ_EN = 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

endpackage

// File: rtl/bus_uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, start-bit validation at half a bit, mid-bit sampling.
module bus_uart_rx
  import bus_uart_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       resb,
  input  logic       rxd,
  output logic [7:0] data_o,
  output logic       push_o,
  output logic       ferr_o
);

  localparam logic [15:0] HALF_END = 16'(DIV / 2 - 1);
  localparam logic [15:0] BIT_END  = 16'(DIV - 1);

  logic        sync1_q, sync2_q, prev_q;
  rx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    push_o  = 1'b0;
    ferr_o  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (sync2_q) begin
            push_o  = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_o  = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // A broken frame must not let a still-low line retrigger a start.
        cnt_d = '0;
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data_o = shift_q;

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART on the 65C02 bus: decode, registers, TX FSM and RX storage.
// Define BUS_UART_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register.
module bus_uart
  import bus_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h8000,
  parameter int          DIV       = 434
) (
  input  logic        clk,
  input  logic        resb,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        we,
  output logic [7:0]  dout,
  output logic        rd_sel,
  output logic        irq,
  input  logic        rxd,
  output logic        txd
);

  localparam logic [15:0] BIT_END = 16'(DIV - 1);

  logic       hit, wr, rd;
  logic [1:0] off;
  assign hit = (addr[15:2] == BASE_ADDR[15:2]);
  assign wr  = hit && we;
  assign rd  = hit && !we;
  assign off = addr[1:0];

  logic [7:0] rx_data, rx_head;
  logic       rx_push, rx_ferr, rx_avail, rx_full, rx_pop, push_ok;

  bus_uart_rx #(.DIV(DIV)) u_rx (
    .clk    (clk),
    .resb   (resb),
    .rxd    (rxd),
    .data_o (rx_data),
    .push_o (rx_push),
    .ferr_o (rx_ferr)
  );

  assign rx_pop  = rd && (off == OFF_DATA) && rx_avail;
  assign push_ok = rx_push && (!rx_full || rx_pop);

`ifdef BUS_UART_RX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (rx_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, push_ok} - {2'b00, rx_pop};
    end
  end

  assign rx_avail = (count_q != 3'd0);
  assign rx_full  = (count_q == 3'd4);
  assign rx_head  = fifo_mem[rd_ptr_q];
`else
  logic [7:0] rbuf_q;
  logic       rbuf_full_q;

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      rbuf_q      <= '0;
      rbuf_full_q <= 1'b0;
    end else begin
      if (push_ok) rbuf_q <= rx_data;
      rbuf_full_q <= push_ok || (rbuf_full_q && !rx_pop);
    end
  end

  assign rx_avail = rbuf_full_q;
  assign rx_full  = rbuf_full_q;
  assign rx_head  = rbuf_q;
`endif

  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d, hold_q, hold_d;
  logic        hold_full_q, hold_full_d, txd_q, txd_d;
  logic        ovr_q, ferr_q, status_wr, tx_accept;
  logic [1:0]  ctrl_q;
  logic [7:0]  rdata, dout_q;
  logic        rd_sel_q;

  assign status_wr = wr && (off == OFF_STATUS);
  assign tx_accept = wr && (off == OFF_DATA) && !hold_full_q;

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
      ctrl_q      <= '0;
      dout_q      <= '0;
      rd_sel_q    <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
      ovr_q       <= (rx_push && rx_full && !rx_pop) || (ovr_q && !status_wr);
      ferr_q      <= rx_ferr || (ferr_q && !status_wr);
      if (wr && (off == OFF_CTRL)) ctrl_q <= din[1:0];
      dout_q      <= rd ? rdata : 8'h00;
      rd_sel_q    <= rd;
    end
  end

  // txd is registered from the current state, so the line lags the FSM by one cycle.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q + 16'd1;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    txd_d       = 1'b1;
    if (tx_accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (hold_full_q) begin
          tx_shift_d  = hold_q;
          hold_full_d = 1'b0;
          tx_state_d  = TX_START;
        end
      end
      TX_START: begin
        txd_d = 1'b0;
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        txd_d = tx_shift_q[0];
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (hold_full_q) begin
            tx_shift_d  = hold_q;
            hold_full_d = 1'b0;
            tx_state_d  = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rdata = 8'h00;
    case (off)
      OFF_DATA: rdata = rx_avail ? rx_head : 8'h00;
      OFF_STATUS: begin
        rdata[ST_RX_AVAIL]  = rx_avail;
        rdata[ST_TX_EMPTY]  = !hold_full_q;
        rdata[ST_OVERRUN]   = ovr_q;
        rdata[ST_FRAME_ERR] = ferr_q;
        rdata[ST_TX_BUSY]   = (tx_state_q != TX_IDLE);
      end
      OFF_CTRL: begin
        rdata[CT_RX_IRQ_EN] = ctrl_q[CT_RX_IRQ_EN];
        rdata[CT_TX_IRQ_EN] = ctrl_q[CT_TX_IRQ_EN];
      end
      default: rdata = 8'h00;
    endcase
  end

  assign irq    = (ctrl_q[CT_RX_IRQ_EN] && rx_avail) || (ctrl_q[CT_TX_IRQ_EN] && !hold_full_q)
                  || ovr_q || ferr_q;
  assign dout   = dout_q;
  assign rd_sel = rd_sel_q;
  assign txd    = txd_q;

endmodule

// File: tb/tb_bus_uart.sv
// Self-checking bench for bus_uart (DIV=8); honours BUS_UART_RX_FIFO_EN for RX capacity.
`timescale 1ns/1ps
module tb_bus_uart;

  localparam int DIV   = 8;
  localparam int FRAME = 10 * DIV;
`ifdef BUS_UART_RX_FIFO_EN
  localparam int RX_CAP = 4;
`else
  localparam int RX_CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        resb = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic        we = 1'b0;
  logic [7:0]  dout;
  logic        rd_sel, irq;
  logic        rxd = 1'b1;
  logic        txd;

  bus_uart #(.BASE_ADDR(16'h8000), .DIV(DIV)) dut (
    .clk(clk), .resb(resb), .addr(addr), .din(din), .we(we),
    .dout(dout), .rd_sel(rd_sel), .irq(irq), .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model state ----------------
  byte unsigned rx_q[$];
  byte unsigned tx_exp[$];
  longint       tx_start[$];
  bit           m_ovr = 0, m_ferr = 0;
  bit [1:0]     m_ctrl = 2'b00;
  int           frames_seen = 0;
  bit           mon_en = 1;
  longint       cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] status_exp(bit avail, bit txe, bit busy);
    return {3'b000, busy, m_ferr, m_ovr, txe, avail};
  endfunction

  function automatic logic irq_exp(bit avail, bit txe);
    return (m_ctrl[0] && avail) || (m_ctrl[1] && txe) || m_ovr || m_ferr;
  endfunction

  // ---------------- bus read-select compare, every cycle ----------------
  bit exp_rd = 0;
  always @(posedge clk or negedge resb)
    if (!resb) exp_rd <= 1'b0;
    else       exp_rd <= (addr >= 16'h8000) && (addr <= 16'h8003) && !we;

  always @(negedge clk) begin
    if (resb) begin
      chk("rd_sel", rd_sel, exp_rd);
      if (!exp_rd) chk("dout_unselected", dout, 8'h00);
    end
  end

  // ---------------- TX line monitor: every cycle of every frame ----------------
  logic [9:0]   mon_fr;
  byte unsigned mon_b;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && resb && txd == 1'b0) begin
        tx_start.push_back(cyc);
        chk("tx_frame_expected", tx_exp.size() > 0, 1);
        mon_b  = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'h00;
        mon_fr = {1'b1, mon_b, 1'b0};
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk);
          if (!resb) break;
          chk("txd_bit", txd, mon_fr[k / DIV]);
        end
        frames_seen++;
      end
    end
  end

  // ---------------- bus and line tasks (called at a negedge) ----------------
  task automatic bus_write(input logic [1:0] off, input logic [7:0] d);
    addr = 16'h8000 + {14'd0, off};
    din  = d;
    we   = 1'b1;
    @(negedge clk);
    addr = 16'h0000;
    din  = 8'h00;
    we   = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [7:0] d);
    addr = 16'h8000 + {14'd0, off};
    we   = 1'b0;
    @(negedge clk);
    d    = dout;
    addr = 16'h0000;
  endtask

  task automatic read_status_chk(input string name, input bit txe, input bit busy,
                                 output logic [7:0] d);
    bit avail;
    avail = rx_q.size() > 0;
    bus_read(2'd1, d);
    chk(name, d, status_exp(avail, txe, busy));
    chk({name, "_irq"}, irq, irq_exp(avail, txe));
  endtask

  task automatic read_data_chk(input string name);
    logic [7:0] d, e;
    e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
    bus_read(2'd0, d);
    chk(name, d, e);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = fr[k];
      repeat (DIV) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic rx_model_push(input byte unsigned b);
    if (rx_q.size() < RX_CAP) rx_q.push_back(b);
    else m_ovr = 1;
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (frames_seen < target && t < 4 * FRAME) begin
      @(negedge clk);
      t++;
    end
    chk("tx_frames_done", frames_seen, target);
    repeat (2 * DIV) @(negedge clk);
    chk("tx_no_extra_frame", frames_seen, target);
  endtask

  // ---------------- main stimulus ----------------
  logic [7:0]   d;
  byte unsigned b;
  int           n, t;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_dout", dout, 8'h00);
    chk("rst_rd_sel", rd_sel, 1'b0);
    chk("rst_irq", irq, 1'b0);
    resb = 1'b1;
    @(negedge clk);
    read_status_chk("st_reset", 1, 0, d);
    chk("st_reset_literal", d, 8'h02);

    // TX: A5, a dropped write, a queued byte, another dropped write
    tx_exp.push_back(8'hA5);
    bus_write(2'd0, 8'hA5);
    bus_write(2'd0, 8'h5A);
    read_status_chk("st_after_xfer", 1, 1, d);
    chk("st_after_xfer_literal", d, 8'h12);
    b = 8'($urandom);
    tx_exp.push_back(b);
    bus_write(2'd0, b);
    bus_write(2'd0, 8'($urandom));
    read_status_chk("st_hold_full", 0, 1, d);
    wait_frames(2);
    chk("tx_back_to_back_gap", 32'(tx_start[1] - tx_start[0]), FRAME);
    read_status_chk("st_tx_done", 1, 0, d);

    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      tx_exp.push_back(b);
      bus_write(2'd0, b);
      repeat (2 * DIV) @(negedge clk);
      read_status_chk("st_tx_busy", 1, 1, d);
      wait_frames(frames_seen + 1);
    end

    // RX: single good frame
    send_frame(8'h3C, 1'b1);
    rx_model_push(8'h3C);
    repeat (4) @(negedge clk);
    read_status_chk("st_rx_avail", 1, 0, d);
    chk("st_rx_avail_literal", d, 8'h03);
    read_data_chk("rx_data_3c");
    read_status_chk("st_rx_popped", 1, 0, d);
    read_data_chk("rx_empty_read");

    // RX: framing error
    send_frame(8'($urandom), 1'b0);
    m_ferr = 1;
    repeat (4) @(negedge clk);
    read_status_chk("st_ferr", 1, 0, d);
    chk("st_ferr_literal", d, 8'h0A);
    bus_write(2'd1, 8'h00);
    m_ferr = 0;
    chk("irq_cleared", irq, 1'b0);
    read_status_chk("st_ferr_clr", 1, 0, d);

    // RX: overrun (11,22 for a single holding register, random bytes for the FIFO)
    for (int i = 0; i <= RX_CAP; i++) begin
      b = (RX_CAP == 1) ? ((i == 0) ? 8'h11 : 8'h22) : 8'($urandom);
      send_frame(b, 1'b1);
      rx_model_push(b);
    end
    repeat (4) @(negedge clk);
    read_status_chk("st_overrun", 1, 0, d);
    for (int i = 0; i <= RX_CAP; i++) read_data_chk("rx_overrun_data");
    bus_write(2'd1, 8'hFF);
    m_ovr = 0;
    read_status_chk("st_ovr_clr", 1, 0, d);

    // RX: randomized bursts
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, RX_CAP + 1);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        send_frame(b, 1'b1);
        rx_model_push(b);
      end
      repeat (4) @(negedge clk);
      read_status_chk("st_rx_burst", 1, 0, d);
      for (int i = 0; i <= n; i++) read_data_chk("rx_burst_data");
      bus_write(2'd1, 8'h00);
      m_ovr = 0;
    end

    // CTRL and interrupt enables
    bus_write(2'd2, 8'hFF);
    m_ctrl = 2'b11;
    bus_read(2'd2, d);
    chk("ctrl_read", d, {6'd0, m_ctrl});
    read_status_chk("st_tx_irq", 1, 0, d);
    bus_write(2'd2, 8'h01);
    m_ctrl = 2'b01;
    read_status_chk("st_rx_irq_idle", 1, 0, d);
    b = 8'($urandom);
    send_frame(b, 1'b1);
    rx_model_push(b);
    repeat (4) @(negedge clk);
    read_status_chk("st_rx_irq", 1, 0, d);
    read_data_chk("rx_irq_data");
    chk("irq_after_pop", irq, 1'b0);
    bus_write(2'd3, 8'hFF);
    bus_read(2'd3, d);
    chk("reg3_read", d, 8'h00);
    bus_write(2'd2, 8'h03);
    m_ctrl = 2'b11;

    // Reset in the middle of a TX frame, then a start-bit glitch
    mon_en = 0;
    bus_write(2'd0, 8'($urandom));
    t = 0;
    while (txd !== 1'b0 && t < 4 * DIV) begin
      @(negedge clk);
      t++;
    end
    chk("txd_low_before_reset", txd, 1'b0);
    #2 resb = 1'b0;
    #1 chk("rst_mid_txd", txd, 1'b1);
    chk("rst_mid_irq", irq, 1'b0);
    rx_q.delete();
    tx_exp.delete();
    m_ovr = 0;
    m_ferr = 0;
    m_ctrl = 2'b00;
    repeat (2) @(negedge clk);
    resb = 1'b1;
    @(negedge clk);
    read_status_chk("st_post_reset", 1, 0, d);
    chk("st_post_reset_literal", d, 8'h02);
    bus_read(2'd2, d);
    chk("ctrl_post_reset", d, 8'h00);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    read_status_chk("st_glitch", 1, 0, d);
    mon_en = 1;
    b = 8'($urandom);
    send_frame(b, 1'b1);
    rx_model_push(b);
    repeat (4) @(negedge clk);
    read_data_chk("rx_after_glitch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
